// File: rtl/gps_sample_packer.sv
// Packs strobed GPS front-end sign samples (optionally sign+magnitude) into 32-bit
// buffer writes. Define GPS_SAMPLE_PACKER_MAG_EN to add gps_rec_mag and pack 2-bit samples.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no capture in progress, waiting for arm
// ARMED   | armed, waiting for the first rising edge of strobed sync
// CAPTURE | packing every strobed sample into words and writing them out
module gps_sample_packer #(
    parameter int DEPTH_LOG2    = 9,
    parameter int START_ON_SYNC = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  sample_stb,
    input  logic                  gps_rec_data,
`ifdef GPS_SAMPLE_PACKER_MAG_EN
    input  logic                  gps_rec_mag,
`endif
    input  logic                  gps_rec_sync,
    input  logic                  arm,
    input  logic                  abort,
    output logic [DEPTH_LOG2-1:0] wr_adr,
    output logic [31:0]           wr_dat,
    output logic                  wr_we,
    output logic                  busy,
    output logic                  done_irq,
    output logic                  gap_err
);

`ifdef GPS_SAMPLE_PACKER_MAG_EN
    localparam int BPS = 2;
`else
    localparam int BPS = 1;
`endif
    localparam int         SPW     = 32 / BPS;
    localparam logic [5:0] SPW_CNT = 6'(SPW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [31-BPS:0]        shift;
    logic [31:0]            shift_nxt;
    logic [5:0]             cnt_left;
    logic [DEPTH_LOG2-1:0]  word_idx;
    logic                   prev_sync;
    logic [BPS-1:0]         smp;

    logic start, pack, word_done, last_word, clr_gap, set_gap;

`ifdef GPS_SAMPLE_PACKER_MAG_EN
    assign smp = {gps_rec_data, gps_rec_mag};
`else
    assign smp = gps_rec_data;
`endif

    assign shift_nxt = {shift, smp};
    assign last_word = (word_idx == {DEPTH_LOG2{1'b1}});
    assign busy      = (state == ARMED) || (state == CAPTURE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        pack      = 1'b0;
        clr_gap   = 1'b0;
        set_gap   = 1'b0;
        case (state)
            IDLE: begin
                if (arm && !abort) begin
                    start     = 1'b1;
                    clr_gap   = 1'b1;
                    state_nxt = (START_ON_SYNC != 0) ? ARMED : CAPTURE;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sample_stb && gps_rec_sync && !prev_sync) begin
                    // the edge sample itself is the first one packed
                    pack      = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_stb) begin
                    pack    = 1'b1;
                    set_gap = !gps_rec_sync;
                end
            end
            default: state_nxt = IDLE;
        endcase

        word_done = pack && (cnt_left == 6'd1);

        // abort still lets a completing word through; it just ends the capture
        if (state == CAPTURE && (abort || (word_done && last_word))) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_we     <= 1'b0;
            done_irq  <= 1'b0;
            wr_adr    <= '0;
            wr_dat    <= '0;
            gap_err   <= 1'b0;
            shift     <= '0;
            cnt_left  <= '0;
            word_idx  <= '0;
            prev_sync <= 1'b0;
        end else begin
            wr_we    <= 1'b0;
            done_irq <= 1'b0;

            if (sample_stb) begin
                prev_sync <= gps_rec_sync;
            end

            if (clr_gap) begin
                gap_err <= 1'b0;
            end else if (set_gap) begin
                gap_err <= 1'b1;
            end

            if (start) begin
                cnt_left <= SPW_CNT;
                word_idx <= '0;
                shift    <= '0;
            end

            if (pack) begin
                if (word_done) begin
                    wr_we    <= 1'b1;
                    wr_dat   <= shift_nxt;
                    wr_adr   <= word_idx;
                    done_irq <= last_word;
                    word_idx <= word_idx + 1'b1;
                    cnt_left <= SPW_CNT;
                    shift    <= '0;
                end else begin
                    shift    <= shift_nxt[31-BPS:0];
                    cnt_left <= cnt_left - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gps_sample_packer.sv
// Bench for gps_sample_packer: one immediate-start and one sync-start instance share
// stimulus; expected words come from a sample-list model grouped into words.
module tb_gps_sample_packer;

`ifdef GPS_SAMPLE_PACKER_MAG_EN
    localparam int BPS = 2;
`else
    localparam int BPS = 1;
`endif
    localparam int SPW = 32 / BPS;
    localparam int DA  = 2;
    localparam int DB  = 3;
    localparam int NA  = 1 << DA;
    localparam int NB  = 1 << DB;

    typedef logic [31:0] wq_t[$];

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic sample_stb = 1'b0;
    logic gps_rec_data = 1'b0;
    logic gps_rec_sync = 1'b0;
    logic arm = 1'b0;
    logic abort = 1'b0;
`ifdef GPS_SAMPLE_PACKER_MAG_EN
    logic mag = 1'b0;
`endif

    logic [DA-1:0] a_adr;
    logic [31:0]   a_dat;
    logic          a_we, a_busy, a_done, a_gap;
    logic [DB-1:0] b_adr;
    logic [31:0]   b_dat;
    logic          b_we, b_busy, b_done, b_gap;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    gps_sample_packer #(.DEPTH_LOG2(DA), .START_ON_SYNC(0)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_stb(sample_stb),
        .gps_rec_data(gps_rec_data),
`ifdef GPS_SAMPLE_PACKER_MAG_EN
        .gps_rec_mag(mag),
`endif
        .gps_rec_sync(gps_rec_sync), .arm(arm), .abort(abort),
        .wr_adr(a_adr), .wr_dat(a_dat), .wr_we(a_we), .busy(a_busy),
        .done_irq(a_done), .gap_err(a_gap)
    );

    gps_sample_packer #(.DEPTH_LOG2(DB), .START_ON_SYNC(1)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_stb(sample_stb),
        .gps_rec_data(gps_rec_data),
`ifdef GPS_SAMPLE_PACKER_MAG_EN
        .gps_rec_mag(mag),
`endif
        .gps_rec_sync(gps_rec_sync), .arm(arm), .abort(abort),
        .wr_adr(b_adr), .wr_dat(b_dat), .wr_we(b_we), .busy(b_busy),
        .done_irq(b_done), .gap_err(b_gap)
    );

    // write monitors
    logic [31:0] a_wd[$];
    int          a_wa[$];
    bit          a_wdone[$];
    int          a_stray = 0;
    logic [31:0] b_wd[$];
    int          b_wa[$];
    bit          b_wdone[$];
    int          b_stray = 0;

    always @(negedge sys_clk) begin
        if (a_we) begin
            a_wd.push_back(a_dat); a_wa.push_back(int'(a_adr)); a_wdone.push_back(a_done);
        end else if (a_done) a_stray++;
        if (b_we) begin
            b_wd.push_back(b_dat); b_wa.push_back(int'(b_adr)); b_wdone.push_back(b_done);
        end else if (b_done) b_stray++;
    end

    // samples strobed since the last arm
    int sv[$];
    bit ss[$];
    bit last_sync = 1'b0;
    bit p_init = 1'b0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input int v, input bit s, input int gap);
        sample_stb   = 1'b1;
        gps_rec_data = v[BPS-1];
`ifdef GPS_SAMPLE_PACKER_MAG_EN
        mag          = v[0];
`endif
        gps_rec_sync = s;
        sv.push_back(v);
        ss.push_back(s);
        last_sync = s;
        tick();
        sample_stb = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    function automatic int rval();
        return int'($urandom_range(0, (1 << BPS) - 1));
    endfunction

    task automatic clear_mon();
        a_wd.delete(); a_wa.delete(); a_wdone.delete(); a_stray = 0;
        b_wd.delete(); b_wa.delete(); b_wdone.delete(); b_stray = 0;
    endtask

    task automatic do_arm();
        abort = 1'b1; tick(); abort = 1'b0; tick();
        clear_mon();
        sv.delete(); ss.delete();
        p_init = last_sync;
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    // Reference: find the start sample, chop the sample list into whole words,
    // stop at buffer full; gap if any packed sample had sync low.
    function automatic void model(input bit sos, input int nwords,
                                  output wq_t words, output bit gap, output bit full);
        int start;
        int nw;
        int last;
        bit prev;
        logic [31:0] word;
        words = {};
        gap = 1'b0;
        full = 1'b0;
        start = sos ? -1 : 0;
        prev = p_init;
        if (sos) begin
            for (int i = 0; i < ss.size(); i++) begin
                if (ss[i] && !prev) begin
                    start = i;
                    break;
                end
                prev = ss[i];
            end
        end
        if (start < 0) return;
        nw = (sv.size() - start) / SPW;
        if (nw >= nwords) begin
            nw = nwords;
            full = 1'b1;
        end
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < SPW; k++) word = (word << BPS) | 32'(sv[start + w * SPW + k]);
            words.push_back(word);
        end
        last = full ? start + nw * SPW : sv.size();
        for (int i = start; i < last; i++) if (!ss[i]) gap = 1'b1;
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        @(negedge sys_clk);
        checks++;
        if ({a_we, a_done, a_busy, a_gap} !== 4'b0 || a_adr !== '0 || a_dat !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: we=%b done=%b busy=%b gap=%b adr=%0d dat=%h expected all zero",
                     a_we, a_done, a_busy, a_gap, a_adr, a_dat);
        end
        checks++;
        if ({b_we, b_done, b_busy, b_gap} !== 4'b0 || b_adr !== '0 || b_dat !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: we=%b done=%b busy=%b gap=%b adr=%0d dat=%h expected all zero",
                     b_we, b_done, b_busy, b_gap, b_adr, b_dat);
        end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alternating();
        wq_t ea; bit ga, fa;
        do_arm();
        for (int i = 0; i < SPW; i++)
            send(((i % 2) == 0) ? ((1 << BPS) - 1) - int'($urandom_range(0, BPS - 1)) : 0, 1'b1,
                 (i == SPW - 1) ? 0 : rgap());
        model(1'b0, NA, ea, ga, fa);
        @(negedge sys_clk);
        checks++;
        if (a_we !== 1'b1 || a_adr !== 2'd0 || a_dat !== ea[0]) begin
            errors++;
            $display("FAIL alt_write: we=%b adr=%0d dat=%h expected we=1 adr=0 dat=%h", a_we, a_adr, a_dat, ea[0]);
        end
`ifndef GPS_SAMPLE_PACKER_MAG_EN
        checks++;
        if (a_dat !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL alt_pattern: dat=%h expected aaaaaaaa", a_dat);
        end
`endif
        @(negedge sys_clk);
        checks++;
        if (a_we !== 1'b0 || a_busy !== 1'b1 || a_wd.size() != 1) begin
            errors++;
            $display("FAIL alt_single: we=%b busy=%b writes=%0d expected we=0 busy=1 writes=1",
                     a_we, a_busy, a_wd.size());
        end
    endtask

    task automatic test_full();
        wq_t ea; bit ga, fa;
        do_arm();
        for (int i = 0; i < NA * SPW; i++) send((1 << BPS) - 1, 1'b1, rgap());
        repeat (3) tick();
        model(1'b0, NA, ea, ga, fa);
        checks++;
        if (a_wd.size() != NA || a_busy !== 1'b0 || a_stray != 0) begin
            errors++;
            $display("FAIL full_count: writes=%0d busy=%b stray_done=%0d expected writes=%0d busy=0 stray=0",
                     a_wd.size(), a_busy, a_stray, NA);
        end
        for (int i = 0; i < a_wd.size() && i < NA; i++) begin
            checks++;
            if (a_wa[i] != i || a_wd[i] !== 32'hFFFFFFFF || a_wd[i] !== ea[i] || a_wdone[i] != (i == NA - 1)) begin
                errors++;
                $display("FAIL full_word%0d: adr=%0d dat=%h done=%b expected adr=%0d dat=ffffffff done=%b",
                         i, a_wa[i], a_wd[i], a_wdone[i], i, (i == NA - 1));
            end
        end
        for (int i = 0; i < 40; i++) send(1, 1'b1, 0);
        repeat (2) tick();
        checks++;
        if (a_wd.size() != NA) begin
            errors++;
            $display("FAIL full_nowrap: writes=%0d expected %0d", a_wd.size(), NA);
        end
    endtask

    task automatic test_sync_start();
        wq_t ea, eb; bit ga, fa, gb, fb;
        send(0, 1'b0, 0);
        do_arm();
        for (int i = 0; i < 5; i++) send(rval(), 1'b0, rgap());
        tick();
        checks++;
        if (b_wd.size() != 0 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL sync_wait: writes=%0d busy=%b expected writes=0 busy=1", b_wd.size(), b_busy);
        end
        for (int i = 0; i < 2 * SPW + 5; i++) send(rval(), 1'b1, rgap());
        repeat (3) tick();
        model(1'b1, NB, eb, gb, fb);
        model(1'b0, NA, ea, ga, fa);
        checks++;
        if (b_wd.size() != 2 || b_wd[0][31] !== 1'(sv[5] >> (BPS - 1))) begin
            errors++;
            $display("FAIL sync_first: writes=%0d bit31=%b expected writes=2 bit31=%b",
                     b_wd.size(), (b_wd.size() > 0) ? b_wd[0][31] : 1'bx, 1'(sv[5] >> (BPS - 1)));
        end
        for (int i = 0; i < b_wd.size() && i < eb.size(); i++) begin
            checks++;
            if (b_wd[i] !== eb[i] || b_wa[i] != i) begin
                errors++;
                $display("FAIL sync_word%0d: adr=%0d dat=%h expected adr=%0d dat=%h", i, b_wa[i], b_wd[i], i, eb[i]);
            end
        end
        checks++;
        if (b_gap !== gb || a_gap !== ga) begin
            errors++;
            $display("FAIL sync_gap: b_gap=%b a_gap=%b expected b_gap=%b a_gap=%b", b_gap, a_gap, gb, ga);
        end
    endtask

    task automatic test_gap();
        wq_t ea; bit ga, fa;
        do_arm();
        for (int i = 0; i < SPW; i++) send(rval(), (i != 10), rgap());
        repeat (2) tick();
        model(1'b0, NA, ea, ga, fa);
        checks++;
        if (a_gap !== 1'b1 || a_wd.size() != 1 || a_wd[0] !== ea[0]) begin
            errors++;
            $display("FAIL gap_word: gap=%b writes=%0d dat=%h expected gap=1 writes=1 dat=%h",
                     a_gap, a_wd.size(), (a_wd.size() > 0) ? a_wd[0] : 32'hx, ea[0]);
        end
        for (int i = 0; i < 10; i++) send(rval(), 1'b1, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (a_gap !== 1'b1) begin
            errors++;
            $display("FAIL gap_sticky: gap=%b expected 1", a_gap);
        end
        do_arm();
        @(negedge sys_clk);
        checks++;
        if (a_gap !== 1'b0) begin
            errors++;
            $display("FAIL gap_clear: gap=%b expected 0", a_gap);
        end
    endtask

    task automatic test_abort();
        wq_t ea; bit ga, fa;
        do_arm();
        for (int i = 0; i < 20; i++) send(rval(), 1'b1, rgap());
        abort = 1'b1; tick(); abort = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b expected 0", a_busy);
        end
        for (int i = 0; i < SPW; i++) send(rval(), 1'b1, 0);
        tick();
        checks++;
        if (a_wd.size() != 0 || a_stray != 0) begin
            errors++;
            $display("FAIL abort_nowrite: writes=%0d stray_done=%0d expected 0 0", a_wd.size(), a_stray);
        end
        do_arm();
        for (int i = 0; i < SPW; i++) send(rval(), 1'b1, rgap());
        repeat (2) tick();
        model(1'b0, NA, ea, ga, fa);
        checks++;
        if (a_wd.size() != 1 || a_wa[0] != 0 || a_wd[0] !== ea[0]) begin
            errors++;
            $display("FAIL abort_rearm: writes=%0d adr=%0d dat=%h expected 1 0 %h", a_wd.size(),
                     (a_wa.size() > 0) ? a_wa[0] : -1, (a_wd.size() > 0) ? a_wd[0] : 32'hx, ea[0]);
        end
    endtask

    task automatic test_abort_coincide();
        wq_t ea; bit ga, fa;
        do_arm();
        for (int i = 0; i < SPW - 1; i++) send(rval(), 1'b1, rgap());
        abort = 1'b1;
        send(rval(), 1'b1, 0);
        abort = 1'b0;
        model(1'b0, NA, ea, ga, fa);
        @(negedge sys_clk);
        checks++;
        if (a_we !== 1'b1 || a_dat !== ea[0] || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_coincide: we=%b dat=%h busy=%b expected we=1 dat=%h busy=0", a_we, a_dat, a_busy, ea[0]);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort_same: a_busy=%b b_busy=%b expected 0 0", a_busy, b_busy);
        end
    endtask

    task automatic test_random();
        wq_t ea, eb; bit ga, fa, gb, fb;
        int n;
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) send(rval(), 1'b0, 0);
            do_arm();
            n = int'($urandom_range(0, NA * SPW + SPW));
            for (int i = 0; i < n; i++) send(rval(), ($urandom_range(0, 7) != 0), rgap());
            repeat (3) tick();
            model(1'b0, NA, ea, ga, fa);
            model(1'b1, NB, eb, gb, fb);
            checks++;
            if (a_wd.size() != ea.size() || a_gap !== ga || a_busy !== !fa || a_stray != 0) begin
                errors++;
                $display("FAIL rand%0d_a: writes=%0d gap=%b busy=%b stray=%0d expected writes=%0d gap=%b busy=%b stray=0",
                         it, a_wd.size(), a_gap, a_busy, a_stray, ea.size(), ga, !fa);
            end
            for (int i = 0; i < a_wd.size() && i < ea.size(); i++) begin
                checks++;
                if (a_wd[i] !== ea[i] || a_wa[i] != i || a_wdone[i] != (fa && i == ea.size() - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_a_word%0d: adr=%0d dat=%h done=%b expected adr=%0d dat=%h done=%b",
                             it, i, a_wa[i], a_wd[i], a_wdone[i], i, ea[i], (fa && i == ea.size() - 1));
                end
            end
            checks++;
            if (b_wd.size() != eb.size() || b_gap !== gb || b_busy !== !fb || b_stray != 0) begin
                errors++;
                $display("FAIL rand%0d_b: writes=%0d gap=%b busy=%b stray=%0d expected writes=%0d gap=%b busy=%b stray=0",
                         it, b_wd.size(), b_gap, b_busy, b_stray, eb.size(), gb, !fb);
            end
            for (int i = 0; i < b_wd.size() && i < eb.size(); i++) begin
                checks++;
                if (b_wd[i] !== eb[i] || b_wa[i] != i) begin
                    errors++;
                    $display("FAIL rand%0d_b_word%0d: adr=%0d dat=%h expected adr=%0d dat=%h",
                             it, i, b_wa[i], b_wd[i], i, eb[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_arm();
        for (int i = 0; i < SPW - 1; i++) send(rval(), 1'b1, rgap());
        sys_rst_n = 1'b0;
        send(rval(), 1'b0, 0);
        @(negedge sys_clk);
        checks++;
        if ({a_we, a_done, a_busy, a_gap} !== 4'b0 || a_adr !== '0 || a_dat !== 32'h0 || a_wd.size() != 0) begin
            errors++;
            $display("FAIL reset_mid: we=%b done=%b busy=%b gap=%b adr=%0d dat=%h writes=%0d expected all zero",
                     a_we, a_done, a_busy, a_gap, a_adr, a_dat, a_wd.size());
        end
        sys_rst_n = 1'b1;
        last_sync = 1'b0;
        repeat (2) tick();
        checks++;
        if (a_wd.size() != 0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: writes=%0d busy=%b expected 0 0", a_wd.size(), a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_full();
        test_sync_start();
        test_gap();
        test_abort();
        test_abort_coincide();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/gps_sample_packer.md
GPS_SAMPLE_PACKER -- requirements
Module: gps_sample_packer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, meaning log2 of capture buffer depth in 32-bit words (512 words).
REQ-002 SHALL have parameter START_ON_SYNC, default 1, meaning 1 = capture begins on the first gps_rec_sync rising edge after arm, 0 = capture begins immediately after arm.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port sample_stb, input, 1, one-cycle strobe marking a valid GPS sample (already in the sys_clk domain).
REQ-006 SHALL have port gps_rec_data, input, 1, sign bit of the sample, valid when sample_stb=1.
REQ-007 SHALL have port gps_rec_sync, input, 1, front-end sync/valid level, sampled only when sample_stb=1.
REQ-008 SHALL have port arm, input, 1, one-cycle pulse that starts a capture.
REQ-009 SHALL have port abort, input, 1, one-cycle pulse that cancels a capture.
REQ-010 SHALL have port wr_adr, output, DEPTH_LOG2, buffer word address.
REQ-011 SHALL have port wr_dat, output, 32, packed sample word.
REQ-012 SHALL have port wr_we, output, 1, one-cycle buffer write enable.
REQ-013 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-014 SHALL have port done_irq, output, 1, one-cycle pulse when the buffer is full.
REQ-015 SHALL have port gap_err, output, 1, sticky flag set when sync drops mid-capture.

Function
REQ-016 SHALL implement FSM IDLE -> ARMED -> CAPTURE -> IDLE; arm is ignored outside IDLE.
REQ-017 In ARMED with START_ON_SYNC=1, SHALL enter CAPTURE on the first strobed sample where sync=1 and the previous strobed sync=0; that sample is the first one packed.
REQ-018 With START_ON_SYNC=0, arm SHALL move IDLE -> CAPTURE directly, and the first strobe after arm is packed.
REQ-019 In CAPTURE, each sample_stb SHALL shift gps_rec_data into a 32-bit shift register, MSB first (first sample ends in bit 31).
REQ-020 On the 32nd sample of a word, the block SHALL assert wr_we for exactly one cycle on the following cycle, with wr_dat = the completed word and wr_adr = the word index.
REQ-021 Word index SHALL start at 0 on each arm and increment after each write; after the write to 2^DEPTH_LOG2-1, done_irq SHALL pulse in the same cycle as that wr_we and the FSM SHALL return to IDLE (no wrap).
REQ-022 A strobed sample with sync=0 during CAPTURE SHALL still be packed and SHALL set gap_err; gap_err clears only on arm or reset.
REQ-023 abort SHALL return the FSM to IDLE next cycle, discard any partial word, produce no wr_we and no done_irq; if abort and a completing write coincide, the write SHALL still occur.
REQ-024 arm and abort in the same cycle: abort wins.
REQ-025 sample_stb on consecutive cycles SHALL be supported at full rate without sample loss.

Reset
REQ-026 On sys_rst_n=0 at a clock edge: FSM=IDLE, wr_we=0, done_irq=0, busy=0, gap_err=0, wr_adr=0, wr_dat=0, the shift register and sample count = 0.
REQ-027 Reset mid-capture SHALL discard all capture state; no write is issued in the reset cycle.

Configuration
REQ-028 With macro GPS_SAMPLE_PACKER_MAG_EN defined, SHALL add input gps_rec_mag (1 bit) and pack 2-bit samples {sign,mag}, 16 samples per word, with the sign of the first sample in bit 31 and its mag in bit 30.
REQ-029 Without GPS_SAMPLE_PACKER_MAG_EN, gps_rec_mag SHALL be absent and 1-bit packing (32 samples/word) applies.

Verification
REQ-030 START_ON_SYNC=0, arm, then 32 strobes with data alternating 1,0,... -> one wr_we, wr_adr=0, wr_dat=0xAAAAAAAA.
REQ-031 DEPTH_LOG2=2, arm, 128 strobes with data=1 -> wr_adr 0,1,2,3 each with 0xFFFFFFFF; done_irq coincident with the 4th wr_we; busy=0 afterwards.
REQ-032 START_ON_SYNC=1, sync low for 5 strobes then high -> no writes before the edge; first word's bit 31 = data at the edge sample.
REQ-033 Sync drops for 1 strobe mid-word -> gap_err=1 and stays 1 until the next arm; the word is still written.
REQ-034 abort after 20 samples -> busy=0 next cycle, no wr_we; re-arm -> wr_adr restarts at 0.
REQ-035 sys_rst_n=0 during CAPTURE at sample 31 -> no wr_we and all outputs take their reset values.
